// File: rtl/fetch_issue_queue_if.sv
// Fetch-packet and decoder-instruction channels of the issue queue.
interface fetch_issue_queue_if #(
    parameter int XPR_LEN               = 32,
    parameter int DECODER_CHANNEL_DEPTH = 4
);
    logic                                 fetch_valid;
    logic                                 fetch_ready;
    logic [XPR_LEN-1:0]                   fetch_pc;
    logic [XPR_LEN*DECODER_CHANNEL_DEPTH-1:0] fetch_data;
    logic                                 drop;
    logic                                 inst_valid;
    logic                                 inst_ready;
    logic [XPR_LEN-1:0]                   inst;
    logic [XPR_LEN-1:0]                   inst_pc;

    modport master (
        output fetch_valid, fetch_pc, fetch_data, drop, inst_ready,
        input  fetch_ready, inst_valid, inst, inst_pc
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_data, drop, inst_ready,
        output fetch_ready, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_issue_queue.sv
// Buffers 4-slot fetch packets and issues one instruction per cycle
// to the decoder, with flush on drop.
module fetch_issue_queue #(
    parameter int XPR_LEN               = 32,
    parameter int DECODER_CHANNEL_DEPTH = 4,
    parameter int QUEUE_DEPTH           = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_issue_queue_if.slave  bus
);
    localparam int SW  = $clog2(DECODER_CHANNEL_DEPTH);
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = PW + 1;
    localparam int PKT = XPR_LEN * DECODER_CHANNEL_DEPTH;
    localparam int BW  = XPR_LEN - SW - 2;

    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_nxt;
    logic [SW-1:0]  cur_slot;
    logic [SW-1:0]  slot_nxt;

    logic [BW-1:0]  q_base  [QUEUE_DEPTH];
    logic [SW-1:0]  q_start [QUEUE_DEPTH];
    logic [PKT-1:0] q_data  [QUEUE_DEPTH];

    logic           push;
    logic           fire;
    logic           last;
    logic           pop;
    logic [SW-1:0]  in_slot;
    logic [BW-1:0]  in_base;
    logic           unused_pc_lsb;

    assign in_slot       = bus.fetch_pc[SW+1:2];
    assign in_base       = bus.fetch_pc[XPR_LEN-1:SW+2];
    assign unused_pc_lsb = ^bus.fetch_pc[1:0];

    assign bus.fetch_ready = (count != CW'(QUEUE_DEPTH));
    assign bus.inst_valid  = (count != '0);

    assign push   = bus.fetch_valid & bus.fetch_ready & ~bus.drop;
    assign fire   = bus.inst_valid & bus.inst_ready;
    assign last   = (cur_slot == SW'(DECODER_CHANNEL_DEPTH - 1));
    assign pop    = fire & last;
    assign rd_nxt = rd_ptr + 1'b1;

    // Outputs read 0 whenever the queue is empty.
    assign bus.inst = bus.inst_valid
                    ? q_data[rd_ptr][cur_slot*XPR_LEN +: XPR_LEN]
                    : '0;
    assign bus.inst_pc = bus.inst_valid
                       ? {q_base[rd_ptr], cur_slot, 2'b00}
                       : '0;

    // A new head takes its start slot from the queue or the incoming packet.
    always_comb begin
        slot_nxt = cur_slot;
        if (pop) begin
            if (count > CW'(1))
                slot_nxt = q_start[rd_nxt];
            else if (push)
                slot_nxt = in_slot;
            else
                slot_nxt = '0;
        end else if (fire) begin
            slot_nxt = cur_slot + 1'b1;
        end else if (push && count == '0) begin
            slot_nxt = in_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cur_slot <= '0;
        end else if (bus.drop) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cur_slot <= '0;
        end else begin
            cur_slot <= slot_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_base[wr_ptr]  <= in_base;
            q_start[wr_ptr] <= in_slot;
            q_data[wr_ptr]  <= bus.fetch_data;
        end
    end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench for fetch_issue_queue: packets queue expected
// instructions, the monitor pops them on every decoder handshake.
module tb_fetch_issue_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   s;
    logic [63:0] sb[$];
    logic [63:0] mon_e;

    fetch_issue_queue_if #(.XPR_LEN(32), .DECODER_CHANNEL_DEPTH(4)) bus();

    fetch_issue_queue #(
        .XPR_LEN(32),
        .DECODER_CHANNEL_DEPTH(4),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] pc, input int k);
        logic [31:0] w;
        if (pc == 32'h1000) begin
            case (k)
                0: w = 32'h13;
                1: w = 32'h93;
                2: w = 32'h113;
                default: w = 32'h193;
            endcase
        end else begin
            w = ({pc[31:4], 4'b0000} + 32'(4 * k)) ^ 32'hDEAD_0000;
        end
        return w;
    endfunction

    task automatic drive_pkt(input logic [31:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        for (int k = 0; k < 4; k++)
            bus.fetch_data[32*k +: 32] = word(pc, k);
    endtask

    task automatic sb_pkt(input logic [31:0] pc);
        for (int k = int'(pc[3:2]); k < 4; k++)
            sb.push_back({word(pc, k), pc[31:4], 2'(k), 2'b00});
    endtask

    task automatic push_chk(input logic [31:0] pc, input logic exp_rdy);
        drive_pkt(pc);
        @(negedge clk);
        chk("fetch_ready", 64'(bus.fetch_ready), 64'(exp_rdy));
        if (exp_rdy) sb_pkt(pc);
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
    endtask

    task automatic push_hold(input logic [31:0] pc);
        bit ok = 0;
        drive_pkt(pc);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.fetch_ready) begin
                sb_pkt(pc);
                ok = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) chk("push_timeout", 64'd1, 64'd0);
        else begin
            @(posedge clk); #1;
        end
        bus.fetch_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            if (sb.size() == 0) begin
                chk("unexp_issue", {bus.inst, bus.inst_pc}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("inst", 64'(bus.inst), 64'(mon_e[63:32]));
                chk("inst_pc", 64'(bus.inst_pc), 64'(mon_e[31:0]));
            end
            last_cyc = cyc;
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_data  = '0;
        bus.drop        = 1'b0;
        bus.inst_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // basic issue
        bus.inst_ready = 1'b1;
        s = cyc;
        push_hold(32'h1000);
        wait_drain();
        chk("basic_span", 64'(last_cyc - s), 64'd4);
        chk("basic_empty", 64'(bus.inst_valid), 64'd0);
        chk("basic_inst0", 64'(bus.inst), 64'd0);

        // unaligned start
        s = cyc;
        push_hold(32'h2008);
        wait_drain();
        chk("unal_span", 64'(last_cyc - s), 64'd2);
        chk("unal_empty", 64'(bus.inst_valid), 64'd0);

        // backpressure / full
        bus.inst_ready = 1'b0;
        push_chk(32'h3000, 1'b1);
        push_chk(32'h3010, 1'b1);
        push_chk(32'h3020, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_inst", 64'(bus.inst), 64'(word(32'h3000, 0)));
            chk("stall_pc", 64'(bus.inst_pc), 64'h3000);
        end
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_ready", 64'(bus.fetch_ready), 64'(i == 4));
        end
        wait_drain();

        // streaming with wrap
        s = cyc;
        push_hold(32'h0);
        push_hold(32'h10);
        push_hold(32'h20);
        push_hold(32'h30);
        wait_drain();
        chk("stream_span", 64'(last_cyc - s), 64'd16);

        // drop mid-packet
        bus.inst_ready = 1'b0;
        push_chk(32'h6000, 1'b1);
        push_chk(32'h6010, 1'b1);
        bus.inst_ready = 1'b1;
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        chk("pre_drop_pc", 64'(bus.inst_pc), 64'h6004);
        @(posedge clk); #1;
        bus.drop = 1'b1;
        drive_pkt(32'h4000);
        @(posedge clk); #1;
        bus.drop        = 1'b0;
        bus.fetch_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("drop_valid", 64'(bus.inst_valid), 64'd0);
        chk("drop_ready", 64'(bus.fetch_ready), 64'd1);
        chk("drop_inst", 64'(bus.inst), 64'd0);
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        s = cyc;
        push_hold(32'h5000);
        wait_drain();
        chk("post_drop_span", 64'(last_cyc - s), 64'd4);

        // asynchronous reset mid-drain
        push_hold(32'h8000);
        push_hold(32'h8010);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.inst_valid), 64'd0);
        chk("arst_ready", 64'(bus.fetch_ready), 64'd1);
        chk("arst_pc", 64'(bus.inst_pc), 64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_idle", 64'(bus.inst_valid), 64'd0);
        s = cyc;
        push_hold(32'h7000);
        wait_drain();
        chk("arst_span", 64'(last_cyc - s), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
